// File: rtl/wb_arbiter_buf.sv
// wb_arbiter_buf: per-FU result FIFOs drained onto WB_PORTS writeback ports, round-robin (MODE 0) or fixed priority (MODE 1).
// Latency: an entry enqueued at edge t is visible on wb_* during cycle t+1; arbitration is combinational from FIFO heads.
// Backpressure: fu_ready[i] drops while FIFO i is full; squashed entries keep their slot until they pop silently.
// Ports: clk/rst (async, active-high); fu_en/fu_robIdx/fu_data/fu_ready per-FU input channels;
//        wb_en/wb_fu/wb_robIdx/wb_data per writeback port; redirect/redirectIdx backend squash request.
module wb_arbiter_buf #(
   parameter int  FU_NUM     = 4,
   parameter int  WB_PORTS   = 2,
   parameter int  BUF_DEPTH  = 4,
   parameter int  DATA_WIDTH = 64,
   parameter int  ROB_WIDTH  = 6,
   parameter int  MODE       = 0,
   localparam int FUW        = (FU_NUM > 1) ? $clog2(FU_NUM) : 1,
   localparam int RW         = ROB_WIDTH + 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [FU_NUM-1:0]              fu_en,
   input  logic [FU_NUM*RW-1:0]           fu_robIdx,
   input  logic [FU_NUM*DATA_WIDTH-1:0]   fu_data,
   output logic [FU_NUM-1:0]              fu_ready,
   output logic [WB_PORTS-1:0]            wb_en,
   output logic [WB_PORTS*FUW-1:0]        wb_fu,
   output logic [WB_PORTS*RW-1:0]         wb_robIdx,
   output logic [WB_PORTS*DATA_WIDTH-1:0] wb_data,
   input  logic                           redirect,
   input  logic [RW-1:0]                  redirectIdx
);
   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;

   logic [RW-1:0]         rob_q    [FU_NUM][BUF_DEPTH];
   logic [DATA_WIDTH-1:0] data_q   [FU_NUM][BUF_DEPTH];
   logic [BUF_DEPTH-1:0]  vld_q    [FU_NUM];
   logic [BUF_DEPTH-1:0]  vld_d    [FU_NUM];
   logic [PW-1:0]         head_q   [FU_NUM];
   logic [PW-1:0]         tail_q   [FU_NUM];
   logic [CW-1:0]         cnt_q    [FU_NUM];
   logic [RW-1:0]         in_rob   [FU_NUM];
   logic [RW-1:0]         head_rob [FU_NUM];
   logic [FUW-1:0]        rr_q;
   logic [FUW-1:0]        rr_d;
   logic [FUW-1:0]        scan_start;
   logic                  any_grant;
   logic [FU_NUM-1:0]     push;
   logic [FU_NUM-1:0]     pop;
   logic [FU_NUM-1:0]     grant;
   logic [FU_NUM-1:0]     silent;
   logic [FU_NUM-1:0]     elig;
   int                    n_grant;
   int                    last_fu;
   int                    scan_fu;

   // ROB age compare across the wrap bit: equal indices are not younger,
   // so the redirecting instruction itself survives.
   function automatic logic younger(input logic [RW-1:0] e, input logic [RW-1:0] r);
      if (e[RW-1] == r[RW-1]) return e[RW-2:0] > r[RW-2:0];
      else                    return e[RW-2:0] < r[RW-2:0];
   endfunction

   // FIFO status, derived from registered state only
   always_comb begin
      for (int i = 0; i < FU_NUM; i++) begin
         in_rob[i]   = fu_robIdx[i*RW +: RW];
         fu_ready[i] = (cnt_q[i] != CW'(BUF_DEPTH));
         push[i]     = fu_en[i] & fu_ready[i];
         head_rob[i] = rob_q[i][head_q[i]];
         silent[i]   = (cnt_q[i] != '0) && !vld_q[i][head_q[i]];
         // a head being squashed right now is already out of the race
         elig[i]     = (cnt_q[i] != '0) && vld_q[i][head_q[i]] &&
                       !(redirect && younger(head_rob[i], redirectIdx));
      end
   end

   // Valid bits: squash stored entries, then the incoming entry (tail slot is free)
   always_comb begin
      for (int i = 0; i < FU_NUM; i++) begin
         vld_d[i] = vld_q[i];
         for (int j = 0; j < BUF_DEPTH; j++) begin
            if (redirect && younger(rob_q[i][j], redirectIdx)) vld_d[i][j] = 1'b0;
         end
         if (push[i]) vld_d[i][tail_q[i]] = !(redirect && younger(in_rob[i], redirectIdx));
      end
   end

   assign scan_start = (MODE == 1) ? '0 : rr_q;

   // Scan from scan_start with wrap; port k takes the k-th eligible FU
   always_comb begin
      wb_en     = '0;
      wb_fu     = '0;
      wb_robIdx = '0;
      wb_data   = '0;
      grant     = '0;
      n_grant   = 0;
      last_fu   = 0;
      scan_fu   = 0;
      for (int s = 0; s < FU_NUM; s++) begin
         scan_fu = int'(scan_start) + s;
         if (scan_fu >= FU_NUM) scan_fu = scan_fu - FU_NUM;
         if (elig[scan_fu] && (n_grant < WB_PORTS)) begin
            grant[scan_fu]                          = 1'b1;
            wb_en[n_grant]                          = 1'b1;
            wb_fu[n_grant*FUW +: FUW]               = FUW'(scan_fu);
            wb_robIdx[n_grant*RW +: RW]             = head_rob[scan_fu];
            wb_data[n_grant*DATA_WIDTH +: DATA_WIDTH] = data_q[scan_fu][head_q[scan_fu]];
            last_fu                                 = scan_fu;
            n_grant                                 = n_grant + 1;
         end
      end
      any_grant = (n_grant != 0);
      if (last_fu + 1 >= FU_NUM) rr_d = '0;
      else                       rr_d = FUW'(last_fu + 1);
   end

   // granted heads and invalid heads share the single pop per FU
   assign pop = grant | silent;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q <= '0;
         for (int i = 0; i < FU_NUM; i++) begin
            head_q[i] <= '0;
            tail_q[i] <= '0;
            cnt_q[i]  <= '0;
            vld_q[i]  <= '0;
         end
      end else begin
         if ((MODE == 0) && any_grant) rr_q <= rr_d;
         for (int i = 0; i < FU_NUM; i++) begin
            vld_q[i] <= vld_d[i];
            if (push[i]) tail_q[i] <= tail_q[i] + PW'(1);
            if (pop[i])  head_q[i] <= head_q[i] + PW'(1);
            if (push[i] && !pop[i])      cnt_q[i] <= cnt_q[i] + CW'(1);
            else if (!push[i] && pop[i]) cnt_q[i] <= cnt_q[i] - CW'(1);
         end
      end
   end

   // Payload storage needs no reset: the valid bits and count gate every read
   always_ff @(posedge clk) begin
      for (int i = 0; i < FU_NUM; i++) begin
         if (push[i]) begin
            rob_q[i][tail_q[i]]  <= in_rob[i];
            data_q[i][tail_q[i]] <= fu_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter_buf.sv
module tb_wb_arbiter_buf;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // dut_a: round-robin, 2 ports; dut_b: fixed priority, 1 port
   logic [3:0]   en_a, en_b;
   logic [27:0]  rob_a, rob_b;
   logic [255:0] dat_a, dat_b;
   logic         redir_a, redir_b;
   logic [6:0]   ridx_a, ridx_b;
   logic [3:0]   fu_ready_a, fu_ready_b;
   logic [1:0]   wb_en_a;
   logic [3:0]   wb_fu_a;
   logic [13:0]  wb_robIdx_a;
   logic [127:0] wb_data_a;
   logic [0:0]   wb_en_b;
   logic [1:0]   wb_fu_b;
   logic [6:0]   wb_robIdx_b;
   logic [63:0]  wb_data_b;

   wb_arbiter_buf #(.FU_NUM(4), .WB_PORTS(2), .BUF_DEPTH(4), .DATA_WIDTH(64), .ROB_WIDTH(6), .MODE(0)) dut_a (
      .clk(clk), .rst(rst), .fu_en(en_a), .fu_robIdx(rob_a), .fu_data(dat_a), .fu_ready(fu_ready_a),
      .wb_en(wb_en_a), .wb_fu(wb_fu_a), .wb_robIdx(wb_robIdx_a), .wb_data(wb_data_a),
      .redirect(redir_a), .redirectIdx(ridx_a));

   wb_arbiter_buf #(.FU_NUM(4), .WB_PORTS(1), .BUF_DEPTH(4), .DATA_WIDTH(64), .ROB_WIDTH(6), .MODE(1)) dut_b (
      .clk(clk), .rst(rst), .fu_en(en_b), .fu_robIdx(rob_b), .fu_data(dat_b), .fu_ready(fu_ready_b),
      .wb_en(wb_en_b), .wb_fu(wb_fu_b), .wb_robIdx(wb_robIdx_b), .wb_data(wb_data_b),
      .redirect(redir_b), .redirectIdx(ridx_b));

   int n_chk = 0;
   int n_err = 0;

   // scoreboard: one in-order queue per (dut, FU); index = dut*4 + fu
   typedef struct packed { logic [6:0] rob; logic [63:0] data; } sb_t;
   typedef sb_t sbq_t[$];
   sbq_t sbq[8];

   typedef struct { int fu; logic [6:0] rob; logic [63:0] data; logic redir; logic [6:0] ridx; logic vis; } vec_t;
   vec_t vt[8];

   bit [8:0]  sq_en_v = 9'b010011110;
   bit [10:0] bp_en_v = 11'b01111111110;
   bit [10:0] bp_rdy_v = 11'b11110001111;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   task automatic clr_in();
      en_a = '0; en_b = '0; redir_a = 1'b0; redir_b = 1'b0;
   endtask

   task automatic drv(input int which, input int fu, input logic [6:0] rob, input logic [63:0] dat, input bit expect_out);
      sb_t e;
      if (which == 0) begin
         en_a[fu] = 1'b1; rob_a[fu*7 +: 7] = rob; dat_a[fu*64 +: 64] = dat;
      end else begin
         en_b[fu] = 1'b1; rob_b[fu*7 +: 7] = rob; dat_b[fu*64 +: 64] = dat;
      end
      e.rob = rob; e.data = dat;
      if (expect_out) sbq[which*4 + fu].push_back(e);
   endtask

   task automatic sb_pop(input int which, input int fu, input logic [6:0] rob, input logic [63:0] dat);
      sb_t e;
      n_chk++;
      if (sbq[which*4 + fu].size() == 0) begin
         n_err++;
         $display("FAIL sb_dut%0d_fu%0d: output rob=%0h data=%0h, expected no output (t=%0t)", which, fu, rob, dat, $time);
      end else begin
         e = sbq[which*4 + fu].pop_front();
         if (e.rob !== rob || e.data !== dat) begin
            n_err++;
            $display("FAIL sb_dut%0d_fu%0d: got rob=%0h data=%0h, expected rob=%0h data=%0h (t=%0t)",
                     which, fu, rob, dat, e.rob, e.data, $time);
         end
      end
   endtask

   // output monitor and FU protocol check
   always @(negedge clk) begin
      if (!rst) begin
         for (int p = 0; p < 2; p++) begin
            if (wb_en_a[p]) sb_pop(0, int'(wb_fu_a[p*2 +: 2]), wb_robIdx_a[p*7 +: 7], wb_data_a[p*64 +: 64]);
         end
         if (wb_en_b[0]) sb_pop(1, int'(wb_fu_b), wb_robIdx_b, wb_data_b);
         if (en_a != 0) chk("fu_protocol_a", {60'd0, en_a & ~fu_ready_a}, 64'd0);
         if (en_b != 0) chk("fu_protocol_b", {60'd0, en_b & ~fu_ready_b}, 64'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{2, 7'd5,   64'hAB,   1'b0, 7'd0,   1'b1};
      vt[1] = '{0, 7'd9,   64'h1001, 1'b1, 7'd8,   1'b0};
      vt[2] = '{1, 7'd8,   64'h1002, 1'b1, 7'd8,   1'b1};
      vt[3] = '{3, 7'd66,  64'h1003, 1'b1, 7'd8,   1'b0};
      vt[4] = '{3, 7'd74,  64'h1004, 1'b1, 7'd8,   1'b1};
      vt[5] = '{0, 7'd3,   64'h1005, 1'b1, 7'd8,   1'b1};
      vt[6] = '{1, 7'd124, 64'h1006, 1'b1, 7'd123, 1'b0};
      vt[7] = '{2, 7'd63,  64'h1007, 1'b1, 7'd64,  1'b1};

      clr_in();
      rob_a = '0; rob_b = '0; dat_a = '0; dat_b = '0; ridx_a = '0; ridx_b = '0;
      rst = 1'b1;

      // reset state
      @(negedge clk);
      chk("rst_wb_en_a", {62'd0, wb_en_a}, 64'd0);
      chk("rst_wb_en_b", {63'd0, wb_en_b}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready_a", {60'd0, fu_ready_a}, 64'hF);
      chk("rst_ready_b", {60'd0, fu_ready_b}, 64'hF);

      // round-robin fairness: all FUs loaded, grants alternate {0,1} / {2,3}
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1; clr_in();
         if (c < 4) for (int f = 0; f < 4; f++) drv(0, f, 7'(c), 64'(f*256 + c), 1'b1);
         @(negedge clk);
         if (c == 0 || c == 9) chk("rr_idle", {62'd0, wb_en_a}, 64'd0);
         else begin
            chk("rr_en", {62'd0, wb_en_a}, 64'd3);
            chk("rr_fu", {60'd0, wb_fu_a}, (c % 2 == 1) ? 64'h4 : 64'hE);
         end
      end

      // single-entry vectors: latency and age rule under same-cycle redirect
      for (int v = 0; v < 8; v++) begin
         @(posedge clk); #1; clr_in();
         drv(0, vt[v].fu, vt[v].rob, vt[v].data, vt[v].vis);
         redir_a = vt[v].redir; ridx_a = vt[v].ridx;
         @(negedge clk);
         chk("vec_no_bypass", {62'd0, wb_en_a}, 64'd0);
         @(posedge clk); #1; clr_in();
         @(negedge clk);
         chk("vec_wb_en", {62'd0, wb_en_a}, vt[v].vis ? 64'd1 : 64'd0);
         if (vt[v].vis) chk("vec_wb_fu", {62'd0, wb_fu_a[1:0]}, 64'(vt[v].fu));
         @(posedge clk); #1;
         @(negedge clk);
         chk("vec_drained", {62'd0, wb_en_a}, 64'd0);
         chk("vec_ready", {60'd0, fu_ready_a}, 64'hF);
      end

      // backpressure: FU0 holds priority, FU1 fills to 4 then drains in order
      for (int c = 0; c < 11; c++) begin
         @(posedge clk); #1; clr_in();
         if (c < 5) drv(1, 0, 7'd1, 64'h2000 + 64'(c), 1'b1);
         if (c < 4) drv(1, 1, 7'd2, 64'h2100 + 64'(c), 1'b1);
         @(negedge clk);
         chk("bp_en", {63'd0, wb_en_b}, 64'(bp_en_v[c]));
         if (bp_en_v[c]) chk("bp_fu", {62'd0, wb_fu_b}, (c >= 6) ? 64'd1 : 64'd0);
         chk("bp_ready1", {63'd0, fu_ready_b[1]}, 64'(bp_rdy_v[c]));
      end

      // squash: {0,7} and {1,1} squashed by redirect {0,5}; {0,3} and {0,5} survive
      for (int c = 0; c < 9; c++) begin
         @(posedge clk); #1; clr_in();
         if (c < 3) drv(1, 0, 7'd0, 64'h3000 + 64'(c), 1'b1);
         if (c == 0) drv(1, 1, 7'd3,  64'h3103, 1'b1);
         if (c == 1) drv(1, 1, 7'd7,  64'h3107, 1'b0);
         if (c == 2) drv(1, 1, 7'd65, 64'h3141, 1'b0);
         if (c == 3) begin
            drv(1, 1, 7'd5, 64'h3105, 1'b1);
            redir_b = 1'b1; ridx_b = 7'd5;
         end
         @(negedge clk);
         chk("sq_en", {63'd0, wb_en_b}, 64'(sq_en_v[c]));
         if (sq_en_v[c]) chk("sq_fu", {62'd0, wb_fu_b}, (c == 4 || c == 7) ? 64'd1 : 64'd0);
         if (c == 4) chk("sq_full", {63'd0, fu_ready_b[1]}, 64'd0);
         if (c == 8) chk("sq_ready", {60'd0, fu_ready_b}, 64'hF);
      end

      // reset mid-traffic with entries buffered
      @(posedge clk); #1; clr_in();
      for (int f = 0; f < 3; f++) drv(1, f, 7'd4, 64'h4000 + 64'(f), 1'b1);
      @(negedge clk);
      chk("mr_no_bypass", {63'd0, wb_en_b}, 64'd0);
      @(posedge clk); #1; clr_in();
      @(negedge clk);
      chk("mr_busy", {63'd0, wb_en_b}, 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("mr_wb_en_b", {63'd0, wb_en_b}, 64'd0);
      chk("mr_wb_en_a", {62'd0, wb_en_a}, 64'd0);
      for (int k = 0; k < 8; k++) sbq[k].delete();
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("mr_ready_b", {60'd0, fu_ready_b}, 64'hF);
         chk("mr_stale_b", {63'd0, wb_en_b}, 64'd0);
      end
      chk("mr_ready_a", {60'd0, fu_ready_a}, 64'hF);

      for (int k = 0; k < 8; k++) chk("sb_drained", 64'(sbq[k].size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
